// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg: shared encodings for the ID/EX control stage.
//   - opcode / funct constants of the supported MIPS subset
//   - PCSRC_*, REGDST_*, MEMTOREG_* field encodings
//   - ALU class constants (low 3 bits of the ALUOp field)
//   - ctrl_bundle_t (every registered control field) and CTRL_BUBBLE
//   - md_state_t, the HI/LO sequencer state (used when MULDIV_EN is defined)
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0a;
  localparam logic [5:0] OP_SLTIU = 6'h0b;
  localparam logic [5:0] OP_ANDI  = 6'h0c;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [5:0] F_SLL   = 6'h00;
  localparam logic [5:0] F_SRL   = 6'h02;
  localparam logic [5:0] F_SRA   = 6'h03;
  localparam logic [5:0] F_JR    = 6'h08;
  localparam logic [5:0] F_JALR  = 6'h09;
  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1a;
  localparam logic [5:0] F_DIVU  = 6'h1b;
  localparam logic [5:0] F_ADD   = 6'h20;
  localparam logic [5:0] F_ADDU  = 6'h21;
  localparam logic [5:0] F_SUB   = 6'h22;
  localparam logic [5:0] F_SUBU  = 6'h23;
  localparam logic [5:0] F_AND   = 6'h24;
  localparam logic [5:0] F_OR    = 6'h25;
  localparam logic [5:0] F_XOR   = 6'h26;
  localparam logic [5:0] F_NOR   = 6'h27;
  localparam logic [5:0] F_SLT   = 6'h2a;
  localparam logic [5:0] F_SLTU  = 6'h2b;

  localparam logic [1:0] PCSRC_SEQ = 2'b00;
  localparam logic [1:0] PCSRC_J   = 2'b01;
  localparam logic [1:0] PCSRC_JR  = 2'b10;

  localparam logic [1:0] REGDST_RT = 2'b00;
  localparam logic [1:0] REGDST_RD = 2'b01;
  localparam logic [1:0] REGDST_RA = 2'b10;

  localparam logic [1:0] MEMTOREG_ALU = 2'b00;
  localparam logic [1:0] MEMTOREG_MEM = 2'b01;
  localparam logic [1:0] MEMTOREG_PC4 = 2'b10;

  localparam logic [2:0] ALU_ADD   = 3'd0;
  localparam logic [2:0] ALU_SUB   = 3'd1;
  localparam logic [2:0] ALU_AND   = 3'd2;
  localparam logic [2:0] ALU_OR    = 3'd3;
  localparam logic [2:0] ALU_SLT   = 3'd4;
  localparam logic [2:0] ALU_FUNCT = 3'd7;

  typedef struct packed {
    logic [1:0] pcsrc;
    logic       branch;
    logic       regwrite;
    logic       memread;
    logic       memwrite;
    logic       alusrc1;
    logic       alusrc2;
    logic       extop;
    logic       luop;
    logic [1:0] regdst;
    logic [1:0] memtoreg;
    logic       alu_sign;   // OpCode[0]: selects unsigned variants in EX
    logic [2:0] alu_class;
  } ctrl_bundle_t;

  localparam ctrl_bundle_t CTRL_BUBBLE = '0;

  typedef enum logic {MD_IDLE = 1'b0, MD_BUSY = 1'b1} md_state_t;

endpackage

// File: rtl/id_ex_ctrl_stage_if.sv
// id_ex_ctrl_stage_if: ID-side inputs and EX-side control outputs of the
// ID/EX control stage.
//   master: drives the IF/ID fields and ex_flush, observes the ex_* bundle
//   slave : the control stage itself
// Handshake: id_valid qualifies the ID fields; when id_stall is 1 the
// producer holds PC and IF/ID unchanged, so the same instruction is offered
// again next cycle. ex_valid qualifies the registered bundle.
// muldiv_state is a debug view of the HI/LO sequencer (1 = BUSY).
interface id_ex_ctrl_stage_if #(parameter int ALUOP_W = 4);
  logic               id_valid;
  logic [5:0]         id_opcode;
  logic [5:0]         id_funct;
  logic [4:0]         id_rs;
  logic [4:0]         id_rt;
  logic               ex_flush;
  logic               id_stall;
  logic               ex_valid;
  logic [1:0]         ex_pcsrc;
  logic               ex_branch;
  logic               ex_regwrite;
  logic               ex_memread;
  logic               ex_memwrite;
  logic               ex_alusrc1;
  logic               ex_alusrc2;
  logic               ex_extop;
  logic               ex_luop;
  logic [1:0]         ex_regdst;
  logic [1:0]         ex_memtoreg;
  logic [ALUOP_W-1:0] ex_aluop;
  logic [4:0]         ex_rt;
  logic               ex_illegal;
  logic               muldiv_start;
  logic               muldiv_busy;
  logic               muldiv_state;

  modport master (
    output id_valid, id_opcode, id_funct, id_rs, id_rt, ex_flush,
    input  id_stall, ex_valid, ex_pcsrc, ex_branch, ex_regwrite, ex_memread,
           ex_memwrite, ex_alusrc1, ex_alusrc2, ex_extop, ex_luop, ex_regdst,
           ex_memtoreg, ex_aluop, ex_rt, ex_illegal, muldiv_start, muldiv_busy,
           muldiv_state
  );

  modport slave (
    input  id_valid, id_opcode, id_funct, id_rs, id_rt, ex_flush,
    output id_stall, ex_valid, ex_pcsrc, ex_branch, ex_regwrite, ex_memread,
           ex_memwrite, ex_alusrc1, ex_alusrc2, ex_extop, ex_luop, ex_regdst,
           ex_memtoreg, ex_aluop, ex_rt, ex_illegal, muldiv_start, muldiv_busy,
           muldiv_state
  );
endinterface

// File: rtl/ctrl_decode.sv
// ctrl_decode: combinational opcode/funct decoder.
//   opcode, funct : instruction [31:26], [5:0]
//   ctrl          : control bundle (CTRL_BUBBLE when illegal)
//   illegal       : unsupported opcode/funct
//   uses_rt       : rt is a source operand (R-type, beq, sw)
//   is_muldiv     : mult/multu/div/divu (MULDIV_EN only, else 0)
//   uses_hilo     : mfhi/mflo (MULDIV_EN only, else 0)
import mips_ctrl_pkg::*;

module ctrl_decode (
  input  logic [5:0]   opcode,
  input  logic [5:0]   funct,
  output ctrl_bundle_t ctrl,
  output logic         illegal,
  output logic         uses_rt,
  output logic         is_muldiv,
  output logic         uses_hilo
);

  always_comb begin
    ctrl      = CTRL_BUBBLE;
    illegal   = 1'b0;
    is_muldiv = 1'b0;
    uses_hilo = 1'b0;
    uses_rt   = (opcode == OP_RTYPE) || (opcode == OP_BEQ) || (opcode == OP_SW);
    case (opcode)
      OP_RTYPE: begin
        ctrl.regwrite  = 1'b1;
        ctrl.regdst    = REGDST_RD;
        ctrl.alu_class = ALU_FUNCT;
        case (funct)
          F_ADD, F_ADDU, F_SUB, F_SUBU, F_AND, F_OR, F_XOR, F_NOR, F_SLT, F_SLTU: ;
          F_SLL, F_SRL, F_SRA: ctrl.alusrc1 = 1'b1;  // shamt is operand A
          F_JR: begin
            ctrl.regwrite = 1'b0;
            ctrl.regdst   = REGDST_RT;
            ctrl.pcsrc    = PCSRC_JR;
          end
          F_JALR: begin
            ctrl.pcsrc    = PCSRC_JR;
            ctrl.memtoreg = MEMTOREG_PC4;
          end
`ifdef MULDIV_EN
          F_MULT, F_MULTU, F_DIV, F_DIVU: begin
            ctrl.regwrite = 1'b0;
            ctrl.regdst   = REGDST_RT;
            is_muldiv     = 1'b1;
          end
          F_MFHI, F_MFLO: uses_hilo = 1'b1;
`endif
          default: begin
            ctrl    = CTRL_BUBBLE;
            illegal = 1'b1;
          end
        endcase
      end
      OP_LW: begin
        ctrl.regwrite = 1'b1;
        ctrl.memread  = 1'b1;
        ctrl.alusrc2  = 1'b1;
        ctrl.extop    = 1'b1;
        ctrl.memtoreg = MEMTOREG_MEM;
      end
      OP_SW: begin
        ctrl.memwrite = 1'b1;
        ctrl.alusrc2  = 1'b1;
        ctrl.extop    = 1'b1;
      end
      OP_BEQ: begin
        ctrl.branch    = 1'b1;
        ctrl.extop     = 1'b1;
        ctrl.alu_class = ALU_SUB;
      end
      OP_J: ctrl.pcsrc = PCSRC_J;
      OP_JAL: begin
        ctrl.pcsrc    = PCSRC_J;
        ctrl.regwrite = 1'b1;
        ctrl.regdst   = REGDST_RA;
        ctrl.memtoreg = MEMTOREG_PC4;
      end
      OP_ADDI, OP_ADDIU: begin
        ctrl.regwrite = 1'b1;
        ctrl.alusrc2  = 1'b1;
        ctrl.extop    = 1'b1;
      end
      OP_ANDI: begin
        ctrl.regwrite  = 1'b1;
        ctrl.alusrc2   = 1'b1;
        ctrl.alu_class = ALU_AND;
      end
      OP_SLTI, OP_SLTIU: begin
        ctrl.regwrite  = 1'b1;
        ctrl.alusrc2   = 1'b1;
        ctrl.extop     = 1'b1;
        ctrl.alu_class = ALU_SLT;
      end
      OP_LUI: begin
        ctrl.regwrite = 1'b1;
        ctrl.alusrc2  = 1'b1;
        ctrl.luop     = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
    // Illegal instructions keep every field at zero, including the sign bit.
    if (!illegal) ctrl.alu_sign = opcode[0];
  end

endmodule

// File: rtl/id_ex_ctrl_stage.sv
// id_ex_ctrl_stage: decodes the ID instruction and registers the control
// bundle into ID/EX, with flush, load-use stall and illegal-opcode flagging.
// Optional feature macro: MULDIV_EN (mult/div/mfhi/mflo legal, HI/LO
// busy sequencer with MULDIV_LAT-cycle occupancy).
//   clk, reset_n : clock, asynchronous active-low reset
//   bus (slave)  : id_* inputs, ex_flush, id_stall, ex_* bundle,
//                  muldiv_start/muldiv_busy, muldiv_state debug view
import mips_ctrl_pkg::*;

module id_ex_ctrl_stage #(
  parameter  int ALUOP_W    = 4,
  parameter  int MULDIV_LAT = 32,
  localparam int CNT_W      = $clog2(MULDIV_LAT + 1)
) (
  input logic              clk,
  input logic              reset_n,
  id_ex_ctrl_stage_if.slave bus
);

  ctrl_bundle_t dec_ctrl;
  logic         dec_illegal, dec_uses_rt, dec_is_muldiv, dec_uses_hilo;

  ctrl_decode u_decode (
    .opcode   (bus.id_opcode),
    .funct    (bus.id_funct),
    .ctrl     (dec_ctrl),
    .illegal  (dec_illegal),
    .uses_rt  (dec_uses_rt),
    .is_muldiv(dec_is_muldiv),
    .uses_hilo(dec_uses_hilo)
  );

  ctrl_bundle_t ex_ctrl_q;
  logic         ex_valid_q, ex_illegal_q;
  logic [4:0]   ex_rt_q;
  logic         load_use, hilo_stall, stall, load;

  assign load_use = bus.id_valid && ex_valid_q && ex_ctrl_q.memread && (ex_rt_q != 5'd0) &&
                    ((ex_rt_q == bus.id_rs) || (dec_uses_rt && (ex_rt_q == bus.id_rt)));

  // A flush kills the ID instruction, so holding it would be pointless.
  assign stall        = !bus.ex_flush && (load_use || hilo_stall);
  assign load         = bus.id_valid && !bus.ex_flush && !stall;
  assign bus.id_stall = stall;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ex_ctrl_q    <= CTRL_BUBBLE;
      ex_valid_q   <= 1'b0;
      ex_illegal_q <= 1'b0;
      ex_rt_q      <= 5'd0;
    end else if (load) begin
      ex_ctrl_q    <= dec_ctrl;
      ex_valid_q   <= 1'b1;
      ex_illegal_q <= dec_illegal;
      ex_rt_q      <= bus.id_rt;
    end else begin
      ex_ctrl_q    <= CTRL_BUBBLE;
      ex_valid_q   <= 1'b0;
      ex_illegal_q <= 1'b0;
      ex_rt_q      <= 5'd0;
    end
  end

  assign bus.ex_valid    = ex_valid_q;
  assign bus.ex_pcsrc    = ex_ctrl_q.pcsrc;
  assign bus.ex_branch   = ex_ctrl_q.branch;
  assign bus.ex_regwrite = ex_ctrl_q.regwrite;
  assign bus.ex_memread  = ex_ctrl_q.memread;
  assign bus.ex_memwrite = ex_ctrl_q.memwrite;
  assign bus.ex_alusrc1  = ex_ctrl_q.alusrc1;
  assign bus.ex_alusrc2  = ex_ctrl_q.alusrc2;
  assign bus.ex_extop    = ex_ctrl_q.extop;
  assign bus.ex_luop     = ex_ctrl_q.luop;
  assign bus.ex_regdst   = ex_ctrl_q.regdst;
  assign bus.ex_memtoreg = ex_ctrl_q.memtoreg;
  assign bus.ex_aluop    = ALUOP_W'({ex_ctrl_q.alu_sign, ex_ctrl_q.alu_class});
  assign bus.ex_rt       = ex_rt_q;
  assign bus.ex_illegal  = ex_illegal_q;

`ifdef MULDIV_EN
  md_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             start_q, start_d;

  assign hilo_stall = bus.id_valid && (state_q == MD_BUSY) && (cnt_q != '0) &&
                      (dec_is_muldiv || dec_uses_hilo);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    start_d = 1'b0;
    case (state_q)
      MD_IDLE: begin
        if (load && dec_is_muldiv) begin
          state_d = MD_BUSY;
          cnt_d   = CNT_W'(MULDIV_LAT - 1);
          start_d = 1'b1;
        end
      end
      MD_BUSY: begin
        if (cnt_q == '0) begin
          // Final busy cycle: a waiting mult/div issues now and re-arms.
          if (load && dec_is_muldiv) begin
            cnt_d   = CNT_W'(MULDIV_LAT - 1);
            start_d = 1'b1;
          end else begin
            state_d = MD_IDLE;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = MD_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      start_q <= start_d;
    end
  end

  assign bus.muldiv_start = start_q;
  assign bus.muldiv_busy  = (state_q == MD_BUSY);
  assign bus.muldiv_state = (state_q == MD_BUSY);
`else
  logic unused_md;
  assign unused_md        = &{1'b0, dec_is_muldiv, dec_uses_hilo};
  assign hilo_stall       = 1'b0;
  assign bus.muldiv_start = 1'b0;
  assign bus.muldiv_busy  = 1'b0;
  assign bus.muldiv_state = 1'b0;
`endif

endmodule

// File: tb/tb_id_ex_ctrl_stage.sv
// tb_id_ex_ctrl_stage: directed bench for id_ex_ctrl_stage with
// hand-computed expected values; MULDIV_EN selects the sequencer checks.
module tb_id_ex_ctrl_stage;

  logic clk = 1'b0;
  logic reset_n;
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;

  id_ex_ctrl_stage_if #(.ALUOP_W(4)) bus ();

  id_ex_ctrl_stage #(.ALUOP_W(4), .MULDIV_LAT(4)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus.slave)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic set_id(input logic v, input logic [5:0] op, input logic [5:0] fn,
                        input logic [4:0] rs, input logic [4:0] rt);
    bus.id_valid  = v;
    bus.id_opcode = op;
    bus.id_funct  = fn;
    bus.id_rs     = rs;
    bus.id_rt     = rt;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n      = 1'b0;
    bus.ex_flush = 1'b0;
    set_id(1'b0, 6'h00, 6'h00, 5'd0, 5'd0);
    repeat (2) tick();
    check("rst_valid",    bus.ex_valid, 0);
    check("rst_regwrite", bus.ex_regwrite, 0);
    check("rst_memread",  bus.ex_memread, 0);
    check("rst_aluop",    bus.ex_aluop, 0);
    check("rst_illegal",  bus.ex_illegal, 0);
    check("rst_rt",       bus.ex_rt, 0);
    check("rst_md_busy",  bus.muldiv_busy, 0);
    check("rst_md_start", bus.muldiv_start, 0);
    reset_n = 1'b1;

    // addi $5,$1,imm
    set_id(1'b1, 6'h08, 6'h00, 5'd1, 5'd5);
    tick();
    check("addi_valid",    bus.ex_valid, 1);
    check("addi_regwrite", bus.ex_regwrite, 1);
    check("addi_alusrc2",  bus.ex_alusrc2, 1);
    check("addi_extop",    bus.ex_extop, 1);
    check("addi_regdst",   bus.ex_regdst, 0);
    check("addi_aluop",    bus.ex_aluop, 4'h0);
    check("addi_rt",       bus.ex_rt, 5);

    // add $x,$2,$3
    set_id(1'b1, 6'h00, 6'h20, 5'd2, 5'd3);
    tick();
    check("add_regdst",  bus.ex_regdst, 1);
    check("add_aluop",   bus.ex_aluop, 4'h7);
    check("add_alusrc2", bus.ex_alusrc2, 0);
    check("add_alusrc1", bus.ex_alusrc1, 0);

    // sll uses shamt as operand A
    set_id(1'b1, 6'h00, 6'h00, 5'd0, 5'd4);
    tick();
    check("sll_alusrc1", bus.ex_alusrc1, 1);

    // lw $8 then add using $8 as rs -> one stall cycle
    set_id(1'b1, 6'h23, 6'h00, 5'd29, 5'd8);
    tick();
    check("lw_memread",  bus.ex_memread, 1);
    check("lw_memtoreg", bus.ex_memtoreg, 1);
    check("lw_aluop",    bus.ex_aluop, 4'h8);
    set_id(1'b1, 6'h00, 6'h20, 5'd8, 5'd10);
    #1;
    check("lu_stall", bus.id_stall, 1);
    tick();
    check("lu_bubble_valid", bus.ex_valid, 0);
    check("lu_bubble_rw",    bus.ex_regwrite, 0);
    check("lu_stall_clear",  bus.id_stall, 0);
    tick();
    check("lu_add_valid", bus.ex_valid, 1);
    check("lu_add_rt",    bus.ex_rt, 10);

    // lw $9 then add reading $9 through rt -> stall
    set_id(1'b1, 6'h23, 6'h00, 5'd29, 5'd9);
    tick();
    set_id(1'b1, 6'h00, 6'h20, 5'd1, 5'd9);
    #1;
    check("lu_rt_stall", bus.id_stall, 1);
    // addi writes rt, does not read it -> no stall
    set_id(1'b1, 6'h08, 6'h00, 5'd1, 5'd9);
    #1;
    check("lu_addi_nostall", bus.id_stall, 0);
    tick();

    // lw $0 then add $0 sources -> never a hazard
    set_id(1'b1, 6'h23, 6'h00, 5'd29, 5'd0);
    tick();
    set_id(1'b1, 6'h00, 6'h20, 5'd0, 5'd0);
    #1;
    check("lu_r0_nostall", bus.id_stall, 0);
    tick();
    check("lu_r0_valid", bus.ex_valid, 1);

    // beq in EX, flush kills the following sw
    set_id(1'b1, 6'h04, 6'h00, 5'd1, 5'd2);
    tick();
    check("beq_branch", bus.ex_branch, 1);
    check("beq_aluop",  bus.ex_aluop, 4'h1);
    set_id(1'b1, 6'h2b, 6'h00, 5'd3, 5'd4);
    bus.ex_flush = 1'b1;
    #1;
    check("flush_nostall", bus.id_stall, 0);
    tick();
    check("flush_valid",    bus.ex_valid, 0);
    check("flush_memwrite", bus.ex_memwrite, 0);

    // flush also suppresses a would-be load-use stall
    bus.ex_flush = 1'b0;
    set_id(1'b1, 6'h23, 6'h00, 5'd29, 5'd8);
    tick();
    set_id(1'b1, 6'h2b, 6'h00, 5'd8, 5'd4);
    bus.ex_flush = 1'b1;
    #1;
    check("flush_lu_nostall", bus.id_stall, 0);
    tick();
    check("flush_lu_valid",    bus.ex_valid, 0);
    check("flush_lu_memwrite", bus.ex_memwrite, 0);
    bus.ex_flush = 1'b0;

    // sw reaches EX normally
    set_id(1'b1, 6'h2b, 6'h00, 5'd3, 5'd4);
    tick();
    check("sw_memwrite", bus.ex_memwrite, 1);
    check("sw_regwrite", bus.ex_regwrite, 0);

    // illegal opcode, then same opcode without id_valid
    set_id(1'b1, 6'h3f, 6'h00, 5'd1, 5'd2);
    tick();
    check("ill_flag",     bus.ex_illegal, 1);
    check("ill_regwrite", bus.ex_regwrite, 0);
    check("ill_memwrite", bus.ex_memwrite, 0);
    check("ill_aluop",    bus.ex_aluop, 0);
    set_id(1'b0, 6'h3f, 6'h00, 5'd1, 5'd2);
    tick();
    check("ill_novalid_flag", bus.ex_illegal, 0);
    check("ill_novalid_valid", bus.ex_valid, 0);

    // jal and jr
    set_id(1'b1, 6'h03, 6'h00, 5'd0, 5'd0);
    tick();
    check("jal_pcsrc",    bus.ex_pcsrc, 1);
    check("jal_regdst",   bus.ex_regdst, 2);
    check("jal_memtoreg", bus.ex_memtoreg, 2);
    check("jal_regwrite", bus.ex_regwrite, 1);
    check("jal_aluop",    bus.ex_aluop, 4'h8);
    set_id(1'b1, 6'h00, 6'h08, 5'd31, 5'd0);
    tick();
    check("jr_pcsrc",    bus.ex_pcsrc, 2);
    check("jr_regwrite", bus.ex_regwrite, 0);

    // lui and andi
    set_id(1'b1, 6'h0f, 6'h00, 5'd0, 5'd6);
    tick();
    check("lui_luop",  bus.ex_luop, 1);
    check("lui_aluop", bus.ex_aluop, 4'h8);
    set_id(1'b1, 6'h0c, 6'h00, 5'd1, 5'd6);
    tick();
    check("andi_extop", bus.ex_extop, 0);
    check("andi_aluop", bus.ex_aluop, 4'h2);

`ifdef MULDIV_EN
    // mult: start pulse, busy for 4 cycles; mflo stalls 3 cycles
    set_id(1'b1, 6'h00, 6'h18, 5'd1, 5'd2);
    tick();
    check("md_start",   bus.muldiv_start, 1);
    check("md_busy0",   bus.muldiv_busy, 1);
    check("md_illegal", bus.ex_illegal, 0);
    set_id(1'b1, 6'h00, 6'h12, 5'd0, 5'd0);
    #1;
    check("md_stall1", bus.id_stall, 1);
    tick();
    check("md_start_drop", bus.muldiv_start, 0);
    check("md_bubble",     bus.ex_valid, 0);
    check("md_stall2",     bus.id_stall, 1);
    tick();
    check("md_stall3", bus.id_stall, 1);
    tick();
    check("md_busy3",    bus.muldiv_busy, 1);
    check("md_issue",    bus.id_stall, 0);
    tick();
    check("mflo_valid",    bus.ex_valid, 1);
    check("mflo_regwrite", bus.ex_regwrite, 1);
    check("md_idle",       bus.muldiv_busy, 0);
`else
    // mult is illegal without the sequencer
    set_id(1'b1, 6'h00, 6'h18, 5'd1, 5'd2);
    tick();
    check("mult_illegal",  bus.ex_illegal, 1);
    check("mult_regwrite", bus.ex_regwrite, 0);
    check("mult_busy",     bus.muldiv_busy, 0);
    check("mult_start",    bus.muldiv_start, 0);
    set_id(1'b0, 6'h00, 6'h00, 5'd0, 5'd0);
    tick();
    check("mult_busy_after", bus.muldiv_busy, 0);
`endif

    // asynchronous reset mid-stream
    set_id(1'b1, 6'h08, 6'h00, 5'd1, 5'd5);
    tick();
    check("pre_rst_valid", bus.ex_valid, 1);
    #3;
    reset_n = 1'b0;
    #1;
    check("async_rst_valid", bus.ex_valid, 0);
    check("async_rst_rw",    bus.ex_regwrite, 0);
    check("async_rst_rt",    bus.ex_rt, 0);
    #2;
    reset_n = 1'b1;
    tick();
    check("post_rst_valid", bus.ex_valid, 1);
    check("post_rst_rw",    bus.ex_regwrite, 1);
    check("post_rst_rt",    bus.ex_rt, 5);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
